// File: rtl/wb_trace_fifo_pkg.sv
// Shared definitions for the write-back trace FIFO: record layout and helpers.
package wb_trace_fifo_pkg;

  // One trace record: PC in bits 68:37, register in 36:32, data in 31:0.
  localparam int TRC_REC_W = 69;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  addr;
    logic [31:0] data;
  } trc_rec_t;

  // Build a record from the three fields observed on the write-back bus.
  function automatic trc_rec_t pack_rec(input logic [31:0] pc,
                                        input logic [4:0]  addr,
                                        input logic [31:0] data);
    trc_rec_t rec;
    rec.pc   = pc;
    rec.addr = addr;
    rec.data = data;
    return rec;
  endfunction

endpackage

// File: rtl/wb_trace_fifo_if.sv
// Bus bundle between the core write-back observation port, the trace consumer and the FIFO.
interface wb_trace_fifo_if #(
  parameter int PTR_W  = 4,
  parameter int DROP_W = 16
);
  logic              w_grf_we;
  logic [4:0]        w_grf_addr;
  logic [31:0]       w_grf_wdata;
  logic [31:0]       w_inst_addr;
  logic              trc_ready;
  logic              drop_clr;
  logic              trc_valid;
  logic [31:0]       trc_pc;
  logic [4:0]        trc_addr;
  logic [31:0]       trc_data;
  logic [PTR_W:0]    count;
  logic              overflow;
  logic [DROP_W-1:0] drop_cnt;

  // The core and the consumer together form the master side.
  modport master (
    output w_grf_we, w_grf_addr, w_grf_wdata, w_inst_addr, trc_ready, drop_clr,
    input  trc_valid, trc_pc, trc_addr, trc_data, count, overflow, drop_cnt
  );

  // The trace FIFO observes the core and serves the consumer.
  modport slave (
    input  w_grf_we, w_grf_addr, w_grf_wdata, w_inst_addr, trc_ready, drop_clr,
    output trc_valid, trc_pc, trc_addr, trc_data, count, overflow, drop_cnt
  );
endinterface

// File: rtl/wb_trace_fifo_ram.sv
// Record storage: register array with one synchronous write port and one async read port.
module wb_trace_fifo_ram
  import wb_trace_fifo_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  trc_rec_t          i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output trc_rec_t          o_rdata
);

  trc_rec_t r_mem [DEPTH];

  // Storage is not reset; the pointers alone decide which entries are meaningful.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/wb_trace_fifo.sv
// Trace FIFO behind the core write-back stage: captures GRF writes, buffers them,
// drains them over valid/ready, and counts (never blocks on) overflow drops.
module wb_trace_fifo
  import wb_trace_fifo_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int PTR_W       = 4,
  parameter int FILTER_ZERO = 1,
  parameter int DROP_W      = 16
) (
  input logic            clk,
  input logic            reset,
  wb_trace_fifo_if.slave bus
);

  localparam logic [PTR_W:0] LP_DEPTH = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W:0]    r_count;
  logic              r_overflow;
  logic [DROP_W-1:0] r_drop_cnt;

  logic     w_valid;
  logic     w_full;
  logic     w_cap;
  logic     w_pop;
  logic     w_push;
  logic     w_drop;
  trc_rec_t w_wrec;
  trc_rec_t w_head;

  assign w_valid = (r_count != '0);
  assign w_full  = (r_count == LP_DEPTH);
  assign w_cap   = bus.w_grf_we && !((FILTER_ZERO != 0) && (bus.w_grf_addr == 5'd0));
  assign w_pop   = w_valid && bus.trc_ready;
  assign w_push  = w_cap && (!w_full || w_pop);
  assign w_drop  = w_cap && w_full && !w_pop;
  assign w_wrec  = pack_rec(bus.w_inst_addr, bus.w_grf_addr, bus.w_grf_wdata);

  wb_trace_fifo_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_wrec),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_head)
  );

  // Pointers wrap naturally at DEPTH; occupancy tracks push minus pop each edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + (PTR_W+1)'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - (PTR_W+1)'(1);
      end
    end
  end

  // Sticky overflow and saturating drop count; a drop in the clearing cycle still counts as one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (bus.drop_clr) begin
        r_drop_cnt <= DROP_W'(1);
      end else if (!(&r_drop_cnt)) begin
        r_drop_cnt <= r_drop_cnt + DROP_W'(1);
      end
    end else if (bus.drop_clr) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end
  end

  assign bus.trc_valid = w_valid;
  assign bus.trc_pc    = w_valid ? w_head.pc   : '0;
  assign bus.trc_addr  = w_valid ? w_head.addr : '0;
  assign bus.trc_data  = w_valid ? w_head.data : '0;
  assign bus.count     = r_count;
  assign bus.overflow  = r_overflow;
  assign bus.drop_cnt  = r_drop_cnt;

endmodule
